// File: rtl/kypd_decimal_entry_if.sv
// Keypad decimal-entry bus: keypad matrix lines plus decoded key and value outputs.
// master = the entry block, slave = the keypad/display/consumer side.
interface kypd_decimal_entry_if;
  logic [3:0]         row_i;
  logic [3:0]         col_o;
  logic [3:0]         key_o;
  logic               key_valid_o;
  logic signed [23:0] entry_o;
  logic signed [23:0] bin_o;
  logic               valid_o;

  modport master (
    input  row_i,
    output col_o, key_o, key_valid_o, entry_o, bin_o, valid_o
  );

  modport slave (
    output row_i,
    input  col_o, key_o, key_valid_o, entry_o, bin_o, valid_o
  );
endinterface

// File: rtl/kypd_decimal_entry.sv
// 4x4 keypad scanner, frame debouncer and signed decimal entry register.
// Optional feature: define KYPD_ENTRY_SIGN_EN to make key A toggle the sign.
module kypd_decimal_entry #(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned SCAN_HZ         = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  kypd_decimal_entry_if.master   bus
);

  localparam int unsigned PERIOD = (CLOCK_FREQUENCY / SCAN_HZ > 0) ? CLOCK_FREQUENCY / SCAN_HZ : 1;
  localparam int unsigned TW     = $clog2(PERIOD + 1);
  localparam int unsigned DW     = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
  localparam logic [DW-1:0] CNT_LAST   = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [26:0]   MAG_MAX    = 27'd8388607;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t state_q, state_d;

  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic          found_q, found_d;
  logic [3:0]    fkey_q, fkey_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic [22:0]   mag_q, mag_d;
  logic          sign_q, sign_d;
  logic signed [23:0] bin_q, bin_d;
  logic          valid_q, valid_d;

  logic          sample, frame_done, col_hit;
  logic [1:0]    col_row;
  logic [26:0]   prod;
  logic signed [23:0] mag_s, entry_w;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: key_map = 4'h1;  4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;  4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;  4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;  4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;  4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;  4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'h0;  4'b11_01: key_map = 4'hF;
      4'b11_10: key_map = 4'hE;  default:  key_map = 4'hD;
    endcase
  endfunction

  // Column timer, column stepping, row synchronizer and per-frame first-hit capture.
  // Rows pass a 2-flop synchronizer; sampling at the end of the period leaves
  // ample settling time after the column change.
  always_comb begin
    sample   = (timer_q == TIMER_LAST);
    timer_d  = sample ? '0 : timer_q + 1'b1;
    col_d    = sample ? col_q + 2'd1 : col_q;
    row_s1_d = bus.row_i;
    row_s2_d = row_s1_q;
    col_hit  = (row_s2_q != 4'hF);
    col_row  = !row_s2_q[0] ? 2'd0 : !row_s2_q[1] ? 2'd1 : !row_s2_q[2] ? 2'd2 : 2'd3;
    found_d  = found_q;
    fkey_d   = fkey_q;
    if (sample) begin
      if (col_q == 2'd0) begin
        found_d = col_hit;
        fkey_d  = key_map(col_row, col_q);
      end else if (!found_q && col_hit) begin
        found_d = 1'b1;
        fkey_d  = key_map(col_row, col_q);
      end
    end
    frame_done = sample && (col_q == 2'd3);
  end

  // Debounce state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Debounce next-state: frame result is found_d/fkey_d in the frame's last sample cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: if (frame_done && found_d) begin
        cand_d  = fkey_d;
        cnt_d   = '0;
        state_d = PRESS_DB;
      end
      PRESS_DB: if (frame_done) begin
        if (found_d && fkey_d == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: if (frame_done && !found_d) begin
        cnt_d   = '0;
        state_d = RELEASE_DB;
      end
      default: if (frame_done) begin
        if (found_d) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Debounce outputs: single accept pulse on the PRESS_DB -> HELD transition.
  always_comb begin
    key_valid_d = (state_q == PRESS_DB) && (state_d == HELD);
    key_d       = key_valid_d ? cand_q : key_q;
  end

  // Entry editing, applied the cycle after the accept pulse.
  always_comb begin
    mag_d   = mag_q;
    sign_d  = sign_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    prod    = {4'd0, mag_q} * 27'd10 + {23'd0, key_q};
    if (key_valid_q) begin
      if (key_q <= 4'd9) begin
        if (prod <= MAG_MAX) mag_d = prod[22:0];
      end else begin
        case (key_q)
          4'hB: mag_d = mag_q / 23'd10;
          4'hC: begin
            mag_d  = '0;
            sign_d = 1'b0;
          end
          4'hD: begin
            bin_d   = entry_w;
            valid_d = 1'b1;
          end
`ifdef KYPD_ENTRY_SIGN_EN
          4'hA: sign_d = !sign_q;
`endif
          default: ;
        endcase
      end
    end
  end

  assign mag_s   = signed'({1'b0, mag_q});
  assign entry_w = sign_q ? -mag_s : mag_s;

  // Scanner, debounce datapath and entry registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q     <= '0;
      col_q       <= '0;
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      found_q     <= 1'b0;
      fkey_q      <= '0;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      mag_q       <= '0;
      sign_q      <= 1'b0;
      bin_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      col_q       <= col_d;
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      found_q     <= found_d;
      fkey_q      <= fkey_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      mag_q       <= mag_d;
      sign_q      <= sign_d;
      bin_q       <= bin_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.col_o       = ~(4'b0001 << col_q);
  assign bus.key_o       = key_q;
  assign bus.key_valid_o = key_valid_q;
  assign bus.entry_o     = entry_w;
  assign bus.bin_o       = bin_q;
  assign bus.valid_o     = valid_q;

endmodule

// File: tb/tb_kypd_decimal_entry.sv
// Directed bench for kypd_decimal_entry with a behavioural 4x4 keypad model.
// Honors KYPD_ENTRY_SIGN_EN for the sign-key expectations.
module tb_kypd_decimal_entry;

  localparam int FRAME = 40;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic       press_en;
  logic [1:0] prow, pcol;

  int   kv_cnt, v_cnt, vbad;
  logic prev_kv;
  logic [3:0] prev_key;

  kypd_decimal_entry_if bus ();

  kypd_decimal_entry #(
    .CLOCK_FREQUENCY(1000),
    .SCAN_HZ(100),
    .DEBOUNCE_FRAMES(4)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.row_i = (press_en && !bus.col_o[pcol]) ? ~(4'b0001 << prow) : 4'hF;

  always @(negedge clk) begin
    if (bus.key_valid_o) kv_cnt <= kv_cnt + 1;
    if (bus.valid_o) begin
      v_cnt <= v_cnt + 1;
      if (!(prev_kv && prev_key == 4'hD)) vbad <= vbad + 1;
    end
    prev_kv  <= bus.key_valid_o;
    prev_key <= bus.key_o;
  end

  function automatic logic [3:0] key_pos(input logic [3:0] code);
    case (code)
      4'h1: key_pos = 4'b00_00; 4'h2: key_pos = 4'b00_01;
      4'h3: key_pos = 4'b00_10; 4'hA: key_pos = 4'b00_11;
      4'h4: key_pos = 4'b01_00; 4'h5: key_pos = 4'b01_01;
      4'h6: key_pos = 4'b01_10; 4'hB: key_pos = 4'b01_11;
      4'h7: key_pos = 4'b10_00; 4'h8: key_pos = 4'b10_01;
      4'h9: key_pos = 4'b10_10; 4'hC: key_pos = 4'b10_11;
      4'h0: key_pos = 4'b11_00; 4'hF: key_pos = 4'b11_01;
      4'hE: key_pos = 4'b11_10; default: key_pos = 4'b11_11;
    endcase
  endfunction

  task automatic hold(input logic [3:0] code, input int frames);
    logic [3:0] p;
    p = key_pos(code);
    @(negedge clk);
    prow = p[3:2];
    pcol = p[1:0];
    press_en = 1'b1;
    repeat (frames * FRAME) @(negedge clk);
  endtask

  task automatic idle(input int frames);
    @(negedge clk);
    press_en = 1'b0;
    repeat (frames * FRAME) @(negedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] code);
    hold(code, 8);
    idle(8);
  endtask

  task automatic check_outputs_reset(input string tag);
    #1;
    checks++; if (bus.col_o !== 4'b1110) begin errors++; $display("FAIL %s col_o got %b want 1110", tag, bus.col_o); end
    checks++; if (bus.key_o !== 4'h0) begin errors++; $display("FAIL %s key_o got %h want 0", tag, bus.key_o); end
    checks++; if (bus.key_valid_o !== 1'b0) begin errors++; $display("FAIL %s key_valid_o got %b want 0", tag, bus.key_valid_o); end
    checks++; if (bus.entry_o !== 24'sd0) begin errors++; $display("FAIL %s entry_o got %0d want 0", tag, bus.entry_o); end
    checks++; if (bus.bin_o !== 24'sd0) begin errors++; $display("FAIL %s bin_o got %0d want 0", tag, bus.bin_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL %s valid_o got %b want 0", tag, bus.valid_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_press();
    int k0;
    k0 = kv_cnt;
    tap(4'h5);
    checks++; if (kv_cnt - k0 !== 1) begin errors++; $display("FAIL press5_pulses got %0d want 1", kv_cnt - k0); end
    checks++; if (bus.key_o !== 4'h5) begin errors++; $display("FAIL press5_key got %h want 5", bus.key_o); end
    checks++; if (bus.entry_o !== 24'sd5) begin errors++; $display("FAIL press5_entry got %0d want 5", bus.entry_o); end
  endtask

  task automatic test_bounce();
    int k0;
    tap(4'hC);
    k0 = kv_cnt;
    hold(4'h7, 2); idle(2);
    hold(4'h7, 2); idle(2);
    hold(4'h7, 8); idle(8);
    checks++; if (kv_cnt - k0 !== 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", kv_cnt - k0); end
    checks++; if (bus.key_o !== 4'h7) begin errors++; $display("FAIL bounce_key got %h want 7", bus.key_o); end
    checks++; if (bus.entry_o !== 24'sd7) begin errors++; $display("FAIL bounce_entry got %0d want 7", bus.entry_o); end
  endtask

  task automatic test_entry_commit();
    int v0;
    tap(4'hC);
    v0 = v_cnt;
    tap(4'h1); tap(4'h2); tap(4'h3); tap(4'hB); tap(4'h4); tap(4'hD);
    checks++; if (bus.entry_o !== 24'sd124) begin errors++; $display("FAIL commit_entry got %0d want 124", bus.entry_o); end
    checks++; if (bus.bin_o !== 24'sd124) begin errors++; $display("FAIL commit_bin got %0d want 124", bus.bin_o); end
    checks++; if (v_cnt - v0 !== 1) begin errors++; $display("FAIL commit_valid_pulses got %0d want 1", v_cnt - v0); end
    checks++; if (vbad !== 0) begin errors++; $display("FAIL commit_valid_timing got %0d misplaced want 0", vbad); end
  endtask

  task automatic test_sign();
    logic signed [23:0] exp_bin;
`ifdef KYPD_ENTRY_SIGN_EN
    exp_bin = -24'sd99;
`else
    exp_bin = 24'sd99;
`endif
    tap(4'hC);
    tap(4'hA); tap(4'h9); tap(4'h9); tap(4'hD);
    checks++; if (bus.bin_o !== exp_bin) begin errors++; $display("FAIL sign_bin got %0d want %0d", bus.bin_o, exp_bin); end
    checks++; if (bus.entry_o !== exp_bin) begin errors++; $display("FAIL sign_entry got %0d want %0d", bus.entry_o, exp_bin); end
    tap(4'hC);
    checks++; if (bus.entry_o !== 24'sd0) begin errors++; $display("FAIL sign_clear_entry got %0d want 0", bus.entry_o); end
    checks++; if (bus.bin_o !== exp_bin) begin errors++; $display("FAIL sign_clear_bin got %0d want %0d", bus.bin_o, exp_bin); end
  endtask

  task automatic test_overflow();
    int k0;
    tap(4'hC);
    tap(4'h8); tap(4'h3); tap(4'h8); tap(4'h8); tap(4'h6); tap(4'h0); tap(4'h7);
    checks++; if (bus.entry_o !== 24'sd8388607) begin errors++; $display("FAIL ovf_max got %0d want 8388607", bus.entry_o); end
    k0 = kv_cnt;
    tap(4'h1);
    checks++; if (kv_cnt - k0 !== 1) begin errors++; $display("FAIL ovf_pulse got %0d want 1", kv_cnt - k0); end
    checks++; if (bus.entry_o !== 24'sd8388607) begin errors++; $display("FAIL ovf_ignored got %0d want 8388607", bus.entry_o); end
    tap(4'hB);
    checks++; if (bus.entry_o !== 24'sd838860) begin errors++; $display("FAIL ovf_backspace got %0d want 838860", bus.entry_o); end
  endtask

  task automatic test_reset_mid_debounce();
    int k0;
    hold(4'h2, 2);
    rst_n = 1'b0;
    k0 = kv_cnt;
    repeat (3) @(negedge clk);
    check_outputs_reset("midreset");
    press_en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    checks++; if (kv_cnt - k0 !== 0) begin errors++; $display("FAIL midreset_pulses got %0d want 0", kv_cnt - k0); end
    checks++; if (bus.entry_o !== 24'sd0) begin errors++; $display("FAIL midreset_entry got %0d want 0", bus.entry_o); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    kv_cnt   = 0;
    v_cnt    = 0;
    vbad     = 0;
    prev_kv  = 1'b0;
    prev_key = 4'h0;
    press_en = 1'b0;
    prow     = 2'd0;
    pcol     = 2'd0;
    rst_n    = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_entry_commit();
    test_sign();
    test_overflow();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kypd_decimal_entry.md
KYPD_DECIMAL_ENTRY -- requirements
Module: kypd_decimal_entry

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 100000000, SHALL be the clk_i frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, SHALL be the column-step rate in Hz; one column period = CLOCK_FREQUENCY/SCAN_HZ clk_i cycles.
REQ-003 Parameter DEBOUNCE_FRAMES, default 4, SHALL be the number of consecutive identical 4-column frames needed to accept a press or a release.
REQ-004 Port clk_i  input  1  SHALL be the single clock; all flops clock on its rising edge.
REQ-005 Port rst_n_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port row_i  input  4  SHALL be the keypad rows, active-low, externally pulled up.
REQ-007 Port col_o  output  4  SHALL be the keypad column drive, active-low one-hot.
REQ-008 Port key_o  output  4  SHALL be the code of the last accepted key.
REQ-009 Port key_valid_o  output  1  SHALL pulse for one clk_i cycle per accepted press.
REQ-010 Port entry_o  output  24 signed  SHALL be the live value being typed, intended to feed the 7-segment display driver.
REQ-011 Port bin_o  output  24 signed  SHALL be the last committed value.
REQ-012 Port valid_o  output  1  SHALL pulse for one clk_i cycle when bin_o is updated.

Function
REQ-013 The scanner SHALL drive columns 0,1,2,3,0,... in order, one column per column period.
REQ-014 The scanner SHALL sample row_i in the last cycle of each column period, then advance to the next column.
REQ-015 The key map SHALL be (row,col): r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D; key_o SHALL carry the hex value of the key.
REQ-016 A frame SHALL report the first low row found, scanning columns 0..3 and rows 0..3 within each column; a frame with no low row SHALL report "none".
REQ-017 The debounce FSM SHALL have the states IDLE, PRESS_DB, HELD and RELEASE_DB.
REQ-018 In IDLE, a key frame SHALL latch the candidate key and move to PRESS_DB.
REQ-019 In PRESS_DB, a frame with a different key or with none SHALL return the FSM to IDLE.
REQ-020 In PRESS_DB, DEBOUNCE_FRAMES matching frames SHALL move the FSM to HELD and pulse key_valid_o.
REQ-021 In HELD, a "none" frame SHALL move the FSM to RELEASE_DB; other frames SHALL keep it in HELD and SHALL NOT repeat the key.
REQ-022 In RELEASE_DB, DEBOUNCE_FRAMES "none" frames SHALL move the FSM to IDLE; any key frame SHALL return it to HELD.
REQ-023 Entry state SHALL be a 23-bit magnitude plus a sign flag; entry_o SHALL equal sign ? -mag : mag.
REQ-024 If key_valid_o pulses in cycle N, the edit SHALL be visible on entry_o from cycle N+1.
REQ-025 Digit keys 0-9 SHALL set mag to mag*10+d.
REQ-026 A digit key that would make mag exceed 8388607 SHALL be ignored and SHALL leave mag unchanged.
REQ-027 Key B (backspace) SHALL set mag to mag/10 and leave the sign unchanged; at mag 0 it SHALL change nothing.
REQ-028 Key C (clear) SHALL set both mag and the sign flag to 0.
REQ-029 Key D (enter) SHALL load bin_o from entry_o and pulse valid_o in cycle N+1, and SHALL leave the entry state unchanged.
REQ-030 Keys E and F SHALL pulse key_valid_o and SHALL have no other effect.
REQ-031 A sign-flag toggle at mag 0 SHALL be retained, while entry_o reads 0.

Reset
REQ-032 While rst_n_i is low, outputs SHALL be: col_o=4'b1110, key_o=0, key_valid_o=0, entry_o=0, bin_o=0, valid_o=0.
REQ-033 While rst_n_i is low, the FSM SHALL be in IDLE, the column and timer counters SHALL be 0, and the sign flag and mag SHALL be 0.
REQ-034 A reset asserted mid-debounce or mid-scan SHALL abandon the pending key, with no key_valid_o pulse after release.

Configuration
REQ-035 With KYPD_ENTRY_SIGN_EN defined, key A SHALL toggle the sign flag.
REQ-036 Without KYPD_ENTRY_SIGN_EN, key A SHALL only pulse key_valid_o, the sign flag SHALL be constant 0, and entry_o and bin_o SHALL never be negative.

Verification
Bench parameters: CLOCK_FREQUENCY=1000, SCAN_HZ=100 (10-cycle column period), DEBOUNCE_FRAMES=4.
REQ-037 Press key 5 for 8 frames, then release -> exactly one key_valid_o pulse with key_o=5, and entry_o=5.
REQ-038 Press key 7 with 2-frame bounces (press/release/press) before a stable hold -> exactly one key_valid_o pulse.
REQ-039 Keys 1,2,3,B,4,D -> entry_o=124, bin_o=124 and one valid_o pulse in the cycle after D's key_valid_o.
REQ-040 With KYPD_ENTRY_SIGN_EN: A,9,9,D -> bin_o=-99; then C -> entry_o=0 and bin_o stays -99. Without the macro: A,9,9,D -> bin_o=99.
REQ-041 Digits 8,3,8,8,6,0,7, then a further 1 -> entry_o=8388607 and the 1 is ignored; then B -> 838860.
REQ-042 Assert rst_n_i during PRESS_DB of key 2 -> all outputs at reset values and no key_valid_o pulse after release.
